layer_seq_ctrl: RTL and testbench
=================================

Name: layer_seq_ctrl

Overview:
- Parametrised sequencer for the CNN inference pipeline. Drives an ordered chain of NUM_LAYERS compute layers (conv, pool, fc, …) using per-layer start-pulse/done handshakes.
- Adds features the fixed three-stage controller lacks: a per-run layer bypass mask, multi-image batch runs, per-layer timeout detection with an error report, abort, and a busy-cycle counter.
- Sits between the core's top-level control and the layer engines; captures the final layer's scalar result once per image.

Parameters:
- NUM_LAYERS, 3, number of sequenced layers; layer 0 is issued first.
- DATA_W, 32, width of the final result.
- BATCH_W, 8, width of the batch image count.
- TIMEOUT, 65535, max WAIT cycles per layer before error; 0 disables the timeout.
- IDX_W, $clog2(NUM_LAYERS) (min 1), width of the layer index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  cancel the run.
- cfg_layer_mask  in  NUM_LAYERS  bit k=1 runs layer k; latched on accepted start.
- cfg_batch  in  BATCH_W  images per run; latched on accepted start; 0 treated as 1.
- layer_start  out  NUM_LAYERS  one-hot, registered, one-cycle start pulse.
- layer_done  in  NUM_LAYERS  done pulse/level from each layer.
- result_in  in  DATA_W  final-layer output (signed, passed through).
- result_out  out  DATA_W  captured result.
- result_valid  out  1  one-cycle pulse per image.
- busy  out  1  run in progress.
- done  out  1  sticky run-complete flag.
- error  out  1  sticky timeout flag.
- err_layer  out  IDX_W  index of the timed-out layer.
- cycle_count  out  32  cycles spent busy in the last run.

Behaviour:
- Reset: all outputs 0; state IDLE; latched configuration and counters cleared.
- States: IDLE, ISSUE, WAIT, ERROR. cur holds the current layer index; img_rem holds the remaining image count.
- IDLE, start=1, abort=0:
  - Latch mask and batch; clear done, error and cycle_count.
  - If mask==0: set done=1 and stay IDLE; no pulses.
  - Otherwise: cur = lowest set mask bit, img_rem = max(cfg_batch,1), go to ISSUE.
- start is ignored in every state other than IDLE.
- busy=1 in ISSUE and WAIT, 0 otherwise.
- cycle_count increments each busy cycle and saturates at 32'hFFFFFFFF.
- ISSUE (exactly 1 cycle): layer_start[cur]=1, all other bits 0. Clear the timeout counter and go to WAIT.
- WAIT:
  - Only layer_done[cur] is honoured. Other done bits, and any done asserted during ISSUE, are ignored.
  - On layer_done[cur] with a higher enabled layer remaining: cur = next enabled index, go to ISSUE. The next start pulse therefore appears in the cycle after done is sampled.
  - On layer_done[cur] with no higher enabled layer:
    - result_out <= result_in on that edge; result_valid=1 for the following cycle.
    - Decrement img_rem.
    - If img_rem was >1: cur = lowest enabled layer, go to ISSUE.
    - Else: set done=1, go to IDLE.
  - Without done: the timeout counter increments. If TIMEOUT!=0 and TIMEOUT consecutive WAIT cycles pass without done, set error=1, err_layer=cur, go to ERROR.
  - If done arrives in the same cycle the timeout would fire, done wins.
- ERROR: no layer_start pulses. error and err_layer are held until rst or abort; abort returns to IDLE with error cleared.
- abort in ISSUE or WAIT: go to IDLE next cycle; layer_start forced 0; no result_valid; done stays 0; error unchanged.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins and the start is dropped.
- A layer_done that arrives late after an abort or error is ignored.
- rst at any point, including mid-operation, restores reset values on the next edge.
- Width rules:
  - result is passed through unmodified, with no sign or width conversion.
  - img_rem uses BATCH_W bits.
  - The timeout counter is 32 bits and compared against TIMEOUT.

Test Plan:
- mask=3'b111, batch=1, each layer_done 5 cycles after its start, result_in=32'hDEADBEEF -> layer_start pulses 001,010,100 (one cycle each, each one cycle after the previous done); one result_valid with result_out=32'hDEADBEEF; done=1, busy=0; cycle_count equals the busy cycles.
- mask=3'b101 -> layer_start[1] never asserted; layer_start[2] pulses one cycle after layer_done[0]; done=1.
- batch=3, mask=3'b111 -> 9 start pulses in order 0,1,2 ×3; 3 result_valid pulses; done only after the third; start pulsed mid-run is ignored.
- TIMEOUT=20, layer_done[1] never asserted -> after 20 WAIT cycles error=1, err_layer=1, busy=0, no further pulses; abort then clears error and returns to IDLE.
- abort during WAIT of layer 0 -> busy=0 next cycle, done=0, no result_valid; a stray late layer_done[0] is ignored; a new start runs normally.
- mask=3'b000 -> done=1 one cycle after start, no pulses. batch=0 -> behaves as batch=1. rst mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/layer_seq_ctrl.sv
// rtl/layer_seq_ctrl.sv - Sequencer issuing start pulses along a masked layer chain, with batching, timeout and abort
module layer_seq_ctrl #(
   parameter int          NUM_LAYERS = 3,
   parameter int          DATA_W     = 32,
   parameter int          BATCH_W    = 8,
   parameter int unsigned TIMEOUT    = 65535,
   parameter int          IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_LAYERS-1:0] cfg_layer_mask,
   input  logic [BATCH_W-1:0]    cfg_batch,
   output logic [NUM_LAYERS-1:0] layer_start,
   input  logic [NUM_LAYERS-1:0] layer_done,
   input  logic [DATA_W-1:0]     result_in,
   output logic [DATA_W-1:0]     result_out,
   output logic                  result_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [IDX_W-1:0]      err_layer,
   output logic [31:0]           cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t                  state, state_n;
   logic [IDX_W-1:0]        cur, cur_n;
   logic [BATCH_W-1:0]      img_rem, img_rem_n;
   logic [NUM_LAYERS-1:0]   mask_q;
   logic [31:0]             to_cnt;
   logic [NUM_LAYERS-1:0]   start_vec;
   logic [IDX_W:0]          nxt;
   logic                    accept, fin, to_fire, cap;

   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_LAYERS-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         if (m[k]) r = IDX_W'(k);
      end
      return r;
   endfunction

   // MSB flags that an enabled layer above c exists; low bits give its index.
   function automatic logic [IDX_W:0] next_above(input logic [NUM_LAYERS-1:0] m,
                                                input logic [IDX_W-1:0]      c);
      logic [IDX_W:0] r;
      r = '0;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         if (m[k] && (k > int'(c))) r = {1'b1, IDX_W'(k)};
      end
      return r;
   endfunction

   assign busy = (state == S_ISSUE) || (state == S_WAIT);

   always_comb begin
      state_n   = state;
      cur_n     = cur;
      img_rem_n = img_rem;
      accept    = 1'b0;
      fin       = 1'b0;
      to_fire   = 1'b0;
      cap       = 1'b0;
      start_vec = '0;
      nxt       = next_above(mask_q, cur);
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               accept = 1'b1;
               if (|cfg_layer_mask) begin
                  state_n   = S_ISSUE;
                  cur_n     = lowest_set(cfg_layer_mask);
                  img_rem_n = (cfg_batch == '0) ? BATCH_W'(1) : cfg_batch;
               end else begin
                  fin = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            state_n = abort ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (layer_done[cur]) begin
               if (nxt[IDX_W]) begin
                  cur_n   = nxt[IDX_W-1:0];
                  state_n = S_ISSUE;
               end else begin
                  cap       = 1'b1;
                  img_rem_n = img_rem - BATCH_W'(1);
                  if (img_rem > BATCH_W'(1)) begin
                     cur_n   = lowest_set(mask_q);
                     state_n = S_ISSUE;
                  end else begin
                     fin     = 1'b1;
                     state_n = S_IDLE;
                  end
               end
            end else if ((TIMEOUT != 0) && (to_cnt >= (32'(TIMEOUT) - 32'd1))) begin
               to_fire = 1'b1;
               state_n = S_ERROR;
            end
         end
         S_ERROR: begin
            if (abort) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      // The pulse is registered so it lines up exactly with the ISSUE cycle.
      if (state_n == S_ISSUE) start_vec[cur_n] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cur          <= '0;
         img_rem      <= '0;
         mask_q       <= '0;
         to_cnt       <= '0;
         layer_start  <= '0;
         result_out   <= '0;
         result_valid <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_layer    <= '0;
         cycle_count  <= '0;
      end else begin
         state        <= state_n;
         cur          <= cur_n;
         img_rem      <= img_rem_n;
         layer_start  <= start_vec;
         result_valid <= cap;
         if (cap) result_out <= result_in;

         if (accept) begin
            mask_q      <= cfg_layer_mask;
            done        <= fin;
            error       <= 1'b0;
            cycle_count <= '0;
         end else begin
            if (fin) done <= 1'b1;
            if (busy && (cycle_count != 32'hFFFF_FFFF)) cycle_count <= cycle_count + 32'd1;
         end

         if (state == S_ISSUE) begin
            to_cnt <= '0;
         end else if ((state == S_WAIT) && (to_cnt != 32'hFFFF_FFFF)) begin
            to_cnt <= to_cnt + 32'd1;
         end

         if (to_fire) begin
            error     <= 1'b1;
            err_layer <= cur;
         end else if ((state == S_ERROR) && abort) begin
            error     <= 1'b0;
            err_layer <= '0;
         end
      end
   end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb/tb_layer_seq_ctrl.sv - Scoreboard bench for layer_seq_ctrl with randomized layer responder
module tb_layer_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [2:0]  cfg_layer_mask;
   logic [7:0]  cfg_batch;
   logic [2:0]  layer_start;
   logic [2:0]  layer_done;
   logic [31:0] result_in, result_out;
   logic        result_valid, busy, done, error;
   logic [1:0]  err_layer;
   logic [31:0] cycle_count;

   int tests = 0;
   int fails = 0;
   int          exp_start[$];
   logic [31:0] exp_res[$];
   int          mon_e;
   logic [2:0]  mon_oh;
   logic [31:0] mon_r;

   layer_seq_ctrl #(.NUM_LAYERS(3), .DATA_W(32), .BATCH_W(8), .TIMEOUT(20)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_layer_mask(cfg_layer_mask), .cfg_batch(cfg_batch),
      .layer_start(layer_start), .layer_done(layer_done),
      .result_in(result_in), .result_out(result_out), .result_valid(result_valid),
      .busy(busy), .done(done), .error(error), .err_layer(err_layer),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every start pulse and every result is matched against the model's queues.
   always @(negedge clk) begin
      if (layer_start != 3'b000) begin
         if (exp_start.size() == 0) begin
            check("unexpected_start", 64'(layer_start), 64'd0);
         end else begin
            mon_e  = exp_start.pop_front();
            mon_oh = 3'b000;
            mon_oh[mon_e] = 1'b1;
            check("start_order", 64'(layer_start), 64'(mon_oh));
         end
      end
      if (result_valid) begin
         if (exp_res.size() == 0) begin
            check("unexpected_result", 64'(result_valid), 64'd0);
         end else begin
            mon_r = exp_res.pop_front();
            check("result_value", 64'(result_out), 64'(mon_r));
         end
      end
   end

   task automatic wait_pulse(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (layer_start != 3'b000) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("pulse_wait", 64'(ok), 64'd1);
   endtask

   // Called at the negedge of the ISSUE cycle; done[k] lands d cycles later.
   task automatic serve_layer(input int k, input int d, input bit fin, input logic [31:0] r);
      logic [2:0] oh, nz;
      oh = 3'b000;
      oh[k] = 1'b1;
      layer_done = 3'($urandom);
      for (int i = 1; i <= d; i++) begin
         @(negedge clk);
         nz             = 3'($urandom) & ~oh;
         result_in      = $urandom;
         cfg_layer_mask = 3'($urandom);
         cfg_batch      = 8'($urandom);
         if (i < d) begin
            start      = 1'($urandom);
            layer_done = nz;
         end else begin
            start      = 1'b0;
            layer_done = nz | oh;
            if (fin) begin
               result_in = r;
               exp_res.push_back(r);
            end
         end
      end
      @(negedge clk);
      layer_done = 3'b000;
   endtask

   task automatic run_job(input logic [2:0] m, input logic [7:0] b, input int dfix,
                          input bit use_r, input logic [31:0] rfix);
      int nimg, hi, cc, d;
      bit ok;
      logic [31:0] r, last_r;
      nimg = (b == 8'd0) ? 1 : int'(b);
      hi = 0;
      for (int k = 0; k < 3; k++) if (m[k]) hi = k;
      for (int i = 0; i < nimg; i++)
         for (int k = 0; k < 3; k++)
            if (m[k]) exp_start.push_back(k);
      @(negedge clk);
      cfg_layer_mask = m;
      cfg_batch      = b;
      start          = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cc     = 0;
      last_r = 32'd0;
      for (int i = 0; i < nimg; i++) begin
         for (int k = 0; k < 3; k++) begin
            if (m[k]) begin
               wait_pulse(ok);
               if (!ok) begin
                  exp_start.delete();
                  exp_res.delete();
                  return;
               end
               d = (dfix != 0) ? dfix : int'($urandom_range(1, 6));
               r = use_r ? rfix : $urandom;
               if (k == hi) last_r = r;
               serve_layer(k, d, k == hi, r);
               cc += d + 1;
            end
         end
      end
      @(negedge clk);
      check("run_done", 64'(done), 64'd1);
      check("run_busy", 64'(busy), 64'd0);
      check("run_error", 64'(error), 64'd0);
      check("run_cycles", 64'(cycle_count), 64'(cc));
      check("run_result", 64'(result_out), 64'(last_r));
      check("run_starts_left", 64'(exp_start.size()), 64'd0);
      check("run_results_left", 64'(exp_res.size()), 64'd0);
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1);
   end

   initial begin
      bit ok;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_layer_mask = 3'b000; cfg_batch = 8'd0;
      layer_done = 3'b000; result_in = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_start", 64'(layer_start), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_error", 64'(error), 64'd0);
      check("reset_cycles", 64'(cycle_count), 64'd0);
      check("reset_result", 64'(result_out), 64'd0);

      run_job(3'b111, 8'd1, 5, 1'b1, 32'hDEADBEEF);
      run_job(3'b101, 8'd1, 0, 1'b0, 32'd0);
      run_job(3'b111, 8'd3, 0, 1'b0, 32'd0);
      run_job(3'b110, 8'd0, 0, 1'b0, 32'd0);
      run_job(3'b011, 8'd1, 20, 1'b0, 32'd0);
      for (int n = 0; n < 12; n++)
         run_job(3'($urandom_range(1, 7)), 8'($urandom_range(0, 3)), 0, 1'b0, 32'd0);

      // Layer 1 never finishes: error after 20 WAIT cycles.
      exp_start.push_back(0);
      exp_start.push_back(1);
      @(negedge clk);
      cfg_layer_mask = 3'b011; cfg_batch = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_pulse(ok);
      serve_layer(0, 3, 1'b0, 32'd0);
      wait_pulse(ok);
      layer_done = 3'b000;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         layer_done = 3'($urandom) & 3'b101;
         if (i == 20) begin
            check("to_pre_error", 64'(error), 64'd0);
            check("to_pre_busy", 64'(busy), 64'd1);
         end
      end
      @(negedge clk);
      check("to_error", 64'(error), 64'd1);
      check("to_err_layer", 64'(err_layer), 64'd1);
      check("to_busy", 64'(busy), 64'd0);
      check("to_done", 64'(done), 64'd0);
      check("to_cycles", 64'(cycle_count), 64'd25);
      layer_done = 3'b010; start = 1'b1; cfg_layer_mask = 3'b111;
      repeat (5) @(negedge clk);
      start = 1'b0; layer_done = 3'b000;
      check("err_hold", 64'(error), 64'd1);
      check("err_hold_layer", 64'(err_layer), 64'd1);
      check("err_hold_busy", 64'(busy), 64'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_err_clear", 64'(error), 64'd0);
      check("abort_err_busy", 64'(busy), 64'd0);

      // Abort in WAIT of layer 0.
      exp_start.push_back(0);
      @(negedge clk);
      cfg_layer_mask = 3'b111; cfg_batch = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_pulse(ok);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_cycles", 64'(cycle_count), 64'd3);
      layer_done = 3'b001;
      repeat (3) @(negedge clk);
      layer_done = 3'b000;
      check("late_done_busy", 64'(busy), 64'd0);
      check("late_done_done", 64'(done), 64'd0);

      // Empty mask completes immediately.
      @(negedge clk);
      cfg_layer_mask = 3'b000; cfg_batch = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("empty_done", 64'(done), 64'd1);
      check("empty_busy", 64'(busy), 64'd0);
      check("empty_cycles", 64'(cycle_count), 64'd0);
      repeat (3) @(negedge clk);
      check("empty_idle", 64'(busy), 64'd0);

      run_job(3'b111, 8'd2, 0, 1'b0, 32'd0);

      // start together with abort in IDLE is dropped.
      @(negedge clk);
      cfg_layer_mask = 3'b111; cfg_batch = 8'd1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", 64'(busy), 64'd0);
      check("abort_start_done", 64'(done), 64'd1);
      repeat (2) @(negedge clk);
      check("abort_start_idle", 64'(busy), 64'd0);

      // Reset in the middle of WAIT.
      exp_start.push_back(1);
      @(negedge clk);
      cfg_layer_mask = 3'b110; cfg_batch = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_pulse(ok);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cycles", 64'(cycle_count), 64'd0);
      check("rst_result", 64'(result_out), 64'd0);
      check("rst_start", 64'(layer_start), 64'd0);
      check("rst_flags", 64'({done, error, result_valid, err_layer}), 64'd0);
      rst = 1'b0;
      run_job(3'b111, 8'd1, 0, 1'b0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
